// File: rtl/red_pitaya_dsp_pkg.sv
// Shared routing codes and commit-scheduler state encoding for the DSP route block.
package red_pitaya_dsp_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ARMED  = 2'd1,
      ST_DELAY  = 2'd2,
      ST_COMMIT = 2'd3
   } route_state_t;

   localparam logic [1:0] OUT_OFF  = 2'b00;
   localparam logic [1:0] OUT_OUT1 = 2'b01;
   localparam logic [1:0] OUT_OUT2 = 2'b10;

   // Input-select codes sit just above the submodule indices; NONE is all-ones.
   function automatic int sel_adc1(input int modules);
      return modules + 2;
   endfunction

   function automatic int sel_adc2(input int modules);
      return modules + 3;
   endfunction

   function automatic int sel_none(input int log_modules);
      return (1 << log_modules) - 1;
   endfunction

endpackage

// File: rtl/red_pitaya_route_regbank.sv
// Shadow/active select storage: bus writes land in shadow, copy moves shadow to active.
// Readback is combinational; zero for any address outside the four select windows.
module red_pitaya_route_regbank
   import red_pitaya_dsp_pkg::*;
#(
   parameter int MODULES     = 8,
   parameter int LOG_MODULES = 4,
   localparam int NSEL       = MODULES + 4,
   localparam int NOUT       = MODULES + 2
) (
   input  logic                          clk_i,
   input  logic                          rstn_i,
   input  logic                          wen,
   input  logic [15:0]                   addr,
   input  logic [LOG_MODULES-1:0]        wdata,
   input  logic                          copy,
   output logic [31:0]                   rd_dat,
   output logic [NSEL*LOG_MODULES-1:0]   input_select_o,
   output logic [NOUT*2-1:0]             output_select_o
);

   logic [LOG_MODULES-1:0] sh_in  [NSEL];
   logic [LOG_MODULES-1:0] ac_in  [NSEL];
   logic [1:0]             sh_out [NOUT];
   logic [1:0]             ac_out [NOUT];

   logic [5:0] sidx;
   logic [4:0] aidx;
   logic       sh_in_hit, sh_out_hit, ac_in_hit, ac_out_hit;

   function automatic logic [LOG_MODULES-1:0] in_rst(input int k);
      int code;
      if (k < MODULES)
         code = (k == 1 || k == 3) ? sel_adc2(MODULES) : sel_adc1(MODULES);
      else if (k == MODULES)
         code = sel_adc1(MODULES);
      else if (k == MODULES + 1)
         code = sel_adc2(MODULES);
      else
         code = sel_none(LOG_MODULES);
      return code[LOG_MODULES-1:0];
   endfunction

   assign sidx       = addr[7:2];
   assign aidx       = addr[6:2];
   assign sh_in_hit  = (addr[15:8] == 8'h01) && (addr[1:0] == 2'b00) && ({26'd0, sidx} < NSEL);
   assign sh_out_hit = (addr[15:8] == 8'h02) && (addr[1:0] == 2'b00) && ({26'd0, sidx} < NOUT);
   assign ac_in_hit  = (addr[15:7] == 9'h006) && (addr[1:0] == 2'b00) && ({27'd0, aidx} < NSEL);
   assign ac_out_hit = (addr[15:7] == 9'h007) && (addr[1:0] == 2'b00) && ({27'd0, aidx} < NOUT);

   // Copy and shadow write share an edge: active takes the pre-write shadow value.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         for (int k = 0; k < NSEL; k++) begin
            sh_in[k] <= in_rst(k);
            ac_in[k] <= in_rst(k);
         end
         for (int k = 0; k < NOUT; k++) begin
            sh_out[k] <= OUT_OFF;
            ac_out[k] <= OUT_OFF;
         end
      end else begin
         for (int k = 0; k < NSEL; k++) begin
            if (copy) ac_in[k] <= sh_in[k];
            if (wen && sh_in_hit && sidx == 6'(k)) sh_in[k] <= wdata;
         end
         for (int k = 0; k < NOUT; k++) begin
            if (copy) ac_out[k] <= sh_out[k];
            if (wen && sh_out_hit && sidx == 6'(k)) sh_out[k] <= wdata[1:0];
         end
      end
   end

   always_comb begin
      rd_dat          = '0;
      input_select_o  = '0;
      output_select_o = '0;
      for (int k = 0; k < NSEL; k++) begin
         input_select_o[k*LOG_MODULES +: LOG_MODULES] = ac_in[k];
         if (sh_in_hit && sidx == 6'(k)) rd_dat[LOG_MODULES-1:0] = sh_in[k];
         if (ac_in_hit && aidx == 5'(k)) rd_dat[LOG_MODULES-1:0] = ac_in[k];
      end
      for (int k = 0; k < NOUT; k++) begin
         output_select_o[k*2 +: 2] = ac_out[k];
         if (sh_out_hit && sidx == 6'(k)) rd_dat[1:0] = sh_out[k];
         if (ac_out_hit && aidx == 5'(k)) rd_dat[1:0] = ac_out[k];
      end
   end

endmodule

// File: rtl/red_pitaya_route_sched.sv
// Routing commit scheduler: arms, waits for a trigger edge plus DELAY, then swaps shadow selects in.
// Active selects change DELAY+2 edges after trig_i is sampled high; bus acks one cycle after any strobe.
module red_pitaya_route_sched
   import red_pitaya_dsp_pkg::*;
#(
   parameter int MODULES     = 8,
   parameter int LOG_MODULES = 4,
   localparam int NSEL       = MODULES + 4,
   localparam int NOUT       = MODULES + 2
) (
   input  logic                          clk_i,
   input  logic                          rstn_i,
   input  logic                          trig_i,
   input  logic [15:0]                   sys_addr,
   input  logic [31:0]                   sys_wdata,
   input  logic                          sys_wen,
   input  logic                          sys_ren,
   output logic [31:0]                   sys_rdata,
   output logic                          sys_ack,
   output logic                          sys_err,
   output logic [NSEL*LOG_MODULES-1:0]   input_select_o,
   output logic [NOUT*2-1:0]             output_select_o,
   output logic                          commit_o,
   output logic                          blank_o
);

   route_state_t state, state_nxt;
   logic [31:0]  delay_reg, delay_cnt, bank_rd, rd_mux;
   logic [15:0]  blank_reg, blank_cnt, commit_cnt;
   logic         auto_rearm, trig_q, trig_qq, trig_rise, load_cnt;
   logic         ctrl_wr, arm, sw_commit, abort_req, do_commit;

   assign ctrl_wr   = sys_wen && (sys_addr == 16'h0000);
   assign arm       = ctrl_wr && sys_wdata[0];
   assign sw_commit = ctrl_wr && sys_wdata[1];
   assign abort_req = ctrl_wr && sys_wdata[2];
   // Edge taken from the registered copy so the commit lands DELAY+2 edges after sampling.
   assign trig_rise = trig_q && !trig_qq;
   assign do_commit = (state == ST_COMMIT);
   assign sys_err   = 1'b0;

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) state <= ST_IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      load_cnt  = 1'b0;
      case (state)
         ST_IDLE:   if (arm) state_nxt = ST_ARMED;
         ST_ARMED:  if (trig_rise) begin
                       if (delay_reg == 32'd0) state_nxt = ST_COMMIT;
                       else begin
                          state_nxt = ST_DELAY;
                          load_cnt  = 1'b1;
                       end
                    end
         ST_DELAY:  if (delay_cnt == 32'd1) state_nxt = ST_COMMIT;
         ST_COMMIT: state_nxt = auto_rearm ? ST_ARMED : ST_IDLE;
         default:   state_nxt = ST_IDLE;
      endcase
      // Abort suppresses arm and sw_commit carried in the same write.
      if (abort_req) begin
         if (state != ST_COMMIT) state_nxt = ST_IDLE;
      end else if (sw_commit) begin
         state_nxt = ST_COMMIT;
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         trig_q     <= 1'b0;
         trig_qq    <= 1'b0;
         delay_reg  <= '0;
         delay_cnt  <= '0;
         blank_reg  <= '0;
         blank_cnt  <= '0;
         auto_rearm <= 1'b0;
         commit_cnt <= '0;
         commit_o   <= 1'b0;
         blank_o    <= 1'b0;
      end else begin
         trig_q  <= trig_i;
         trig_qq <= trig_q;
         if (load_cnt)               delay_cnt <= delay_reg;
         else if (state == ST_DELAY) delay_cnt <= delay_cnt - 32'd1;
         if (ctrl_wr) auto_rearm <= sys_wdata[3];
         if (sys_wen && sys_addr == 16'h0008) delay_reg <= sys_wdata;
         if (sys_wen && sys_addr == 16'h000C) blank_reg <= sys_wdata[15:0];
         commit_o <= do_commit;
         if (do_commit) commit_cnt <= commit_cnt + 16'd1;
         if (do_commit)               blank_cnt <= blank_reg;
         else if (blank_cnt != 16'd0) blank_cnt <= blank_cnt - 16'd1;
         blank_o <= (blank_cnt != 16'd0);
      end
   end

   always_comb begin
      case (sys_addr)
         16'h0004: rd_mux = {commit_cnt, 14'd0, state};
         16'h0008: rd_mux = delay_reg;
         16'h000C: rd_mux = {16'd0, blank_reg};
         default:  rd_mux = bank_rd;
      endcase
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         sys_ack   <= 1'b0;
         sys_rdata <= '0;
      end else begin
         sys_ack   <= sys_wen || sys_ren;
         sys_rdata <= sys_ren ? rd_mux : 32'd0;
      end
   end

   red_pitaya_route_regbank #(
      .MODULES     (MODULES),
      .LOG_MODULES (LOG_MODULES)
   ) u_regbank (
      .clk_i           (clk_i),
      .rstn_i          (rstn_i),
      .wen             (sys_wen),
      .addr            (sys_addr),
      .wdata           (sys_wdata[LOG_MODULES-1:0]),
      .copy            (do_commit),
      .rd_dat          (bank_rd),
      .input_select_o  (input_select_o),
      .output_select_o (output_select_o)
   );

endmodule

// File: tb/tb_red_pitaya_route_sched.sv
// Directed bench for the route scheduler: reset map, trigger timing, abort, blanking, commit-cycle writes.
module tb_red_pitaya_route_sched;

   localparam int MODULES = 8;
   localparam int LOG_MODULES = 4;
   localparam int NSEL = MODULES + 4;
   localparam int NOUT = MODULES + 2;

   logic                        clk_i = 1'b0;
   logic                        rstn_i = 1'b0;
   logic                        trig_i = 1'b0;
   logic [15:0]                 sys_addr = '0;
   logic [31:0]                 sys_wdata = '0;
   logic                        sys_wen = 1'b0;
   logic                        sys_ren = 1'b0;
   logic [31:0]                 sys_rdata;
   logic                        sys_ack;
   logic                        sys_err;
   logic [NSEL*LOG_MODULES-1:0] input_select_o;
   logic [NOUT*2-1:0]           output_select_o;
   logic                        commit_o;
   logic                        blank_o;

   int          n_chk = 0;
   int          n_pass = 0;
   int          n_commit;
   logic [31:0] rd;
   logic [12:0] commit_vec, blank_vec, out_vec;

   red_pitaya_route_sched #(.MODULES(MODULES), .LOG_MODULES(LOG_MODULES)) dut (
      .clk_i(clk_i), .rstn_i(rstn_i), .trig_i(trig_i),
      .sys_addr(sys_addr), .sys_wdata(sys_wdata), .sys_wen(sys_wen), .sys_ren(sys_ren),
      .sys_rdata(sys_rdata), .sys_ack(sys_ack), .sys_err(sys_err),
      .input_select_o(input_select_o), .output_select_o(output_select_o),
      .commit_o(commit_o), .blank_o(blank_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic bus_wr(input logic [15:0] a, input logic [31:0] d);
      @(negedge clk_i);
      sys_addr = a; sys_wdata = d; sys_wen = 1'b1;
      @(negedge clk_i);
      sys_wen = 1'b0;
   endtask

   task automatic bus_rd(input logic [15:0] a, output logic [31:0] d);
      @(negedge clk_i);
      sys_addr = a; sys_ren = 1'b1;
      @(negedge clk_i);
      sys_ren = 1'b0;
      d = sys_rdata;
      chk("rd_ack", {31'd0, sys_ack}, 32'd1);
   endtask

   task automatic count_commits(input int cycles, output int n);
      n = 0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk_i);
         if (commit_o) n++;
      end
   endtask

   initial begin
      repeat (3) @(negedge clk_i);
      rstn_i = 1'b1;

      // Reset state
      chk("rst_in_slot1", {28'd0, input_select_o[7:4]}, 32'd11);
      chk("rst_in_slot8", {28'd0, input_select_o[35:32]}, 32'd10);
      chk("rst_in_slot10", {28'd0, input_select_o[43:40]}, 32'd15);
      chk("rst_out_sel", {12'd0, output_select_o}, 32'd0);
      chk("rst_commit_blank", {30'd0, commit_o, blank_o}, 32'd0);
      chk("rst_ack_rdata", {31'd0, sys_ack} | sys_rdata, 32'd0);
      chk("rst_err", {31'd0, sys_err}, 32'd0);

      // DELAY=0 trigger commit of out_sel[5]
      bus_wr(16'h0214, 32'd3);
      bus_wr(16'h0000, 32'h1);
      bus_rd(16'h0004, rd);
      chk("t2_armed", rd, 32'h0000_0001);
      @(negedge clk_i) trig_i = 1'b1;
      @(negedge clk_i) trig_i = 1'b0;
      @(negedge clk_i);
      chk("t2_pre_out", {30'd0, output_select_o[11:10]}, 32'd0);
      chk("t2_pre_commit", {31'd0, commit_o}, 32'd0);
      @(negedge clk_i);
      chk("t2_out", {30'd0, output_select_o[11:10]}, 32'd3);
      chk("t2_commit", {31'd0, commit_o}, 32'd1);
      @(negedge clk_i);
      chk("t2_commit_end", {31'd0, commit_o}, 32'd0);
      bus_rd(16'h0004, rd);
      chk("t2_status", rd, 32'h0001_0000);
      bus_rd(16'h0394, rd);
      chk("t2_active_rd", rd, 32'd3);

      // Abort during DELAY
      bus_wr(16'h0200, 32'd2);
      bus_wr(16'h0008, 32'd10);
      bus_wr(16'h0000, 32'h1);
      @(negedge clk_i) trig_i = 1'b1;
      @(negedge clk_i) trig_i = 1'b0;
      repeat (3) @(negedge clk_i);
      bus_wr(16'h0000, 32'h4);
      count_commits(15, n_commit);
      chk("t3_no_commit", n_commit, 32'd0);
      chk("t3_out0", {30'd0, output_select_o[1:0]}, 32'd0);
      bus_rd(16'h0004, rd);
      chk("t3_status", rd, 32'h0001_0000);
      bus_rd(16'h0008, rd);
      chk("t3_delay_rd", rd, 32'd10);

      // DELAY=4, BLANK=3, auto_rearm; second edge during DELAY ignored
      bus_wr(16'h0008, 32'd4);
      bus_wr(16'h000C, 32'd3);
      bus_wr(16'h0000, 32'h9);
      commit_vec = '0; blank_vec = '0; out_vec = '0;
      @(negedge clk_i) trig_i = 1'b1;
      for (int k = 0; k < 13; k++) begin
         @(negedge clk_i);
         if (k == 0 || k == 3) trig_i = 1'b0;
         if (k == 2) trig_i = 1'b1;
         commit_vec[k] = commit_o;
         blank_vec[k]  = blank_o;
         out_vec[k]    = (output_select_o[1:0] == 2'd2);
      end
      chk("t4_commit_o", {19'd0, commit_vec}, {19'd0, 13'b0_0000_0100_0000});
      chk("t4_blank_o", {19'd0, blank_vec}, {19'd0, 13'b0_0011_1000_0000});
      chk("t4_out_change", {19'd0, out_vec}, {19'd0, 13'b1_1111_1100_0000});
      bus_rd(16'h0004, rd);
      chk("t4_status", rd, 32'h0002_0001);

      // Shadow write in the COMMIT cycle lands after the copy
      bus_wr(16'h0100, 32'd5);
      bus_wr(16'h0008, 32'd0);
      bus_wr(16'h0000, 32'h8);
      @(negedge clk_i) trig_i = 1'b1;
      @(negedge clk_i) trig_i = 1'b0;
      @(negedge clk_i);
      sys_addr = 16'h0100; sys_wdata = 32'd7; sys_wen = 1'b1;
      @(negedge clk_i);
      sys_wen = 1'b0;
      chk("t5_commit", {31'd0, commit_o}, 32'd1);
      chk("t5_slot0_old", {28'd0, input_select_o[3:0]}, 32'd5);
      bus_rd(16'h0100, rd);
      chk("t5_shadow_rd", rd, 32'd7);
      bus_rd(16'h0300, rd);
      chk("t5_active_rd", rd, 32'd5);
      bus_wr(16'h0000, 32'h2);
      @(negedge clk_i);
      chk("t5_slot0_new", {28'd0, input_select_o[3:0]}, 32'd7);
      bus_rd(16'h0004, rd);
      chk("t5_status", rd, 32'h0004_0000);
      bus_wr(16'h0000, 32'h7);
      count_commits(4, n_commit);
      chk("t5_abort_wins", n_commit, 32'd0);
      bus_rd(16'h0004, rd);
      chk("t5_abort_status", rd, 32'h0004_0000);

      // commit_cnt wrap and unmapped reads
      @(negedge clk_i);
      force dut.commit_cnt = 16'hFFFF;
      @(negedge clk_i);
      release dut.commit_cnt;
      bus_rd(16'h0004, rd);
      chk("t6_cnt_max", rd, 32'hFFFF_0000);
      bus_wr(16'h0000, 32'h2);
      @(negedge clk_i);
      bus_rd(16'h0004, rd);
      chk("t6_cnt_wrap", rd, 32'h0000_0000);
      bus_rd(16'h07FC, rd);
      chk("t6_unmapped", rd, 32'd0);
      bus_wr(16'h0130, 32'd9);
      bus_rd(16'h0130, rd);
      chk("t6_out_of_range", rd, 32'd0);
      bus_rd(16'h000C, rd);
      chk("t6_blank_rd", rd, 32'd3);

      // Reset in the middle of DELAY
      bus_wr(16'h0008, 32'd5);
      bus_wr(16'h0000, 32'h1);
      @(negedge clk_i) trig_i = 1'b1;
      @(negedge clk_i) trig_i = 1'b0;
      @(negedge clk_i) rstn_i = 1'b0;
      #1;
      chk("t7_rst_out", {12'd0, output_select_o}, 32'd0);
      chk("t7_rst_slot0", {28'd0, input_select_o[3:0]}, 32'd10);
      @(negedge clk_i) rstn_i = 1'b1;
      count_commits(10, n_commit);
      chk("t7_no_commit", n_commit, 32'd0);
      bus_rd(16'h0004, rd);
      chk("t7_status", rd, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/red_pitaya_route_sched.md
RED_PITAYA_ROUTE_SCHED -- requirements
Module: red_pitaya_route_sched

Interface
REQ-001 SHALL have parameter MODULES, default 8: number of DSP submodules.
REQ-002 SHALL have parameter LOG_MODULES, default 4: width of one input-select code.
REQ-003 SHALL use NSEL = MODULES+4 input-select slots (modules, scope1/2, pwm0/1) and NOUT = MODULES+2 output-select slots (modules, asg1/2).
REQ-004 SHALL have port clk_i  in  1: the only clock.
REQ-005 SHALL have port rstn_i  in  1: reset, asynchronous, active-low.
REQ-006 SHALL have port trig_i  in  1: synchronous commit trigger, rising-edge sensitive.
REQ-007 SHALL have port sys_addr  in  16: local bus address.
REQ-008 SHALL have port sys_wdata  in  32: bus write data.
REQ-009 SHALL have port sys_wen  in  1: bus write strobe.
REQ-010 SHALL have port sys_ren  in  1: bus read strobe.
REQ-011 SHALL have port sys_rdata  out  32: bus read data.
REQ-012 SHALL have port sys_ack  out  1: bus acknowledge.
REQ-013 SHALL have port sys_err  out  1: bus error, constantly 0.
REQ-014 SHALL have port input_select_o  out  NSEL*LOG_MODULES: active routing codes; slot k occupies bits [k*LOG_MODULES +: LOG_MODULES].
REQ-015 SHALL have port output_select_o  out  NOUT*2: active DAC-enable pairs (bit0 OUT1, bit1 OUT2).
REQ-016 SHALL have port commit_o  out  1: one-cycle pulse, coincident with the cycle the active selects change.
REQ-017 SHALL have port blank_o  out  1: high while the post-commit mute window runs.

Function
REQ-018 SHALL keep a shadow copy and an active copy of every select; bus writes go to the shadow only; the active copy drives the outputs.
REQ-019 SHALL use this map: 0x000 CTRL (w: bit0 arm, bit1 sw_commit, bit2 abort, bit3 auto_rearm [stored]); 0x004 STATUS (r: [1:0] state, [31:16] commit_cnt); 0x008 DELAY 32b; 0x00C BLANK 16b; 0x100+4k shadow input_select k; 0x200+4k shadow output_select k; 0x300+4k active input_select k (r); 0x380+4k active output_select k (r).
REQ-020 SHALL assert sys_ack one cycle after sys_wen|sys_ren for every address; unmapped or out-of-range addresses return rdata 0 and ignore writes.
REQ-021 SHALL implement FSM IDLE(0), ARMED(1), DELAY(2), COMMIT(3).
REQ-022 IDLE->ARMED on arm; ARMED->COMMIT on trig_i rising edge when DELAY==0, else ->DELAY with counter loaded to DELAY.
REQ-023 DELAY SHALL decrement each cycle and go to COMMIT on the cycle the counter equals 1.
REQ-024 COMMIT SHALL last one cycle: active<=shadow, commit_o=1, commit_cnt+1 (wraps 0xFFFF->0), blank counter loaded with BLANK; next state is ARMED if auto_rearm else IDLE.
REQ-025 Active outputs SHALL change exactly DELAY+2 clock edges after the edge at which trig_i is first sampled high.
REQ-026 sw_commit SHALL force COMMIT next cycle from any state.
REQ-027 abort SHALL return to IDLE from ARMED or DELAY; abort wins over sw_commit and arm in the same write.
REQ-028 trig_i edges in IDLE, DELAY or COMMIT SHALL be ignored; arm in ARMED/DELAY has no effect.
REQ-029 A shadow write in the COMMIT cycle SHALL land after the copy; the active copy takes the pre-write value.
REQ-030 blank_o SHALL be high for exactly BLANK cycles starting the cycle after commit_o; BLANK=0 means never; a new commit reloads it.

Reset
REQ-031 On rstn_i low, shadow and active SHALL both be set to: input_select slots 0..MODULES-1 = ADC1 (MODULES+2), except slots 1 and 3 = ADC2 (MODULES+3); scope1 = ADC1; scope2 = ADC2; pwm0/1 = NONE (2^LOG_MODULES-1); all output_select = OFF.
REQ-032 Reset SHALL also set state IDLE, DELAY 0, BLANK 0, auto_rearm 0, commit_cnt 0, commit_o 0, blank_o 0, sys_ack 0, sys_rdata 0; reset mid-DELAY aborts with no commit.

Structure
REQ-033 SHALL take ADC1/ADC2/NONE/OFF/OUT1/OUT2 codes and the FSM state encoding from shared package red_pitaya_dsp_pkg.
REQ-034 SHALL place shadow/active storage with readback muxing in one sub-module, red_pitaya_route_regbank.

Verification
REQ-035 After reset, input_select_o slot1 = 11, slot8 = 10, slot10 = 15, output_select_o = 0.
REQ-036 Write shadow out_sel[5]=3, DELAY=0, arm, pulse trig_i -> active out_sel[5]=3 two edges after trig_i is sampled, commit_o one cycle, STATUS.commit_cnt=1, state IDLE.
REQ-037 DELAY=10, arm, trig_i, abort at cycle 5 -> no commit_o, active unchanged, state IDLE.
REQ-038 DELAY=4, BLANK=3, auto_rearm=1 -> commit at trig_i edge +6 edges, blank_o high for 3 cycles, state ARMED; second trig_i edge in DELAY ignored.
REQ-039 Write shadow in_sel[0]=7 in the same cycle as COMMIT -> active slot0 takes the old shadow value; a later sw_commit yields 7.
REQ-040 Force commit_cnt to 0xFFFF, commit -> 0x0000; read 0x7FC -> rdata 0 with ack.
